// File: rtl/spi_pkg.sv
// Shared SPI definitions: initiator modes, peripheral FSM states and default frame widths.
package spi_pkg;

    localparam int SPI_CMD_W  = 8;
    localparam int SPI_RESP_W = 24;

    typedef enum logic [1:0] {
        SPI_TX,
        SPI_RX,
        SPI_TX_RX
    } spi_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP,
        DONE
    } spi_periph_state_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// Signal bundle between an SPI initiator/sample source (master) and the SPI peripheral (slave).
interface spi_peripheral_if
    import spi_pkg::*;
#(
    parameter int CMD_W  = SPI_CMD_W,
    parameter int RESP_W = SPI_RESP_W
);

    logic              sclk;
    logic              cs_l;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [RESP_W-1:0] sample;
    logic              sample_valid;
    logic              drdy_l;
    logic [CMD_W-1:0]  cmd;
    logic              cmd_valid;
    logic              frame_done;
    logic              frame_abort;

    modport master (
        output sclk, cs_l, mosi, sample, sample_valid,
        input  miso, miso_oe, drdy_l, cmd, cmd_valid, frame_done, frame_abort
    );

    modport slave (
        input  sclk, cs_l, mosi, sample, sample_valid,
        output miso, miso_oe, drdy_l, cmd, cmd_valid, frame_done, frame_abort
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered-history edge detect; rise/fall are single-cycle pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: receives a command, then returns the held sample word MSB first.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int CMD_W       = SPI_CMD_W,
    parameter int RESP_W      = SPI_RESP_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_peripheral_if.slave  bus
);

    localparam int CNT_W = $clog2(CMD_W + RESP_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(CMD_W + RESP_W - 1);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .din(bus.sclk),
        .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .rst_n(rst_n), .din(bus.cs_l),
        .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(bus.mosi),
        .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_periph_state_t state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              miso, miso_n, oe, oe_n;
    logic              done, done_n, abort, abort_n;
    logic              shift_cmd, load_cmd, shift_resp;

    logic [CMD_W-2:0]  cmd_shift;
    logic [CMD_W-1:0]  cmd_next, cmd_r;
    logic              cmd_valid;
    logic [RESP_W-1:0] resp_shift, hold;
    logic              drdy_l;

    assign cmd_next = {cmd_shift, mosi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            miso  <= 1'b0;
            oe    <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            miso  <= miso_n;
            oe    <= oe_n;
            done  <= done_n;
            abort <= abort_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        miso_n     = miso;
        oe_n       = oe;
        done_n     = 1'b0;
        abort_n    = 1'b0;
        shift_cmd  = 1'b0;
        load_cmd   = 1'b0;
        shift_resp = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_n = CMD;
                    cnt_n   = '0;
                    oe_n    = 1'b1;
                    miso_n  = 1'b0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                    oe_n    = 1'b0;
                    miso_n  = 1'b0;
                end else if (sclk_rise) begin
                    shift_cmd = 1'b1;
                    cnt_n     = cnt + 1'b1;
                    if (cnt == CMD_LAST) begin
                        load_cmd = 1'b1;
                        state_n  = RESP;
                    end
                end
            end
            RESP: begin
                if (cs_rise) begin
                    state_n = IDLE;
                    abort_n = 1'b1;
                    oe_n    = 1'b0;
                    miso_n  = 1'b0;
                end else if (sclk_fall) begin
                    miso_n     = resp_shift[RESP_W-1];
                    shift_resp = 1'b1;
                    cnt_n      = cnt + 1'b1;
                    if (cnt == RESP_LAST) state_n = DONE;
                end
            end
            DONE: begin
                // counter holds at CMD_W+RESP_W here; extra clocks only flush zeros
                if (cs_rise) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    oe_n    = 1'b0;
                    miso_n  = 1'b0;
                end else if (sclk_rise || sclk_fall) begin
                    miso_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_shift  <= '0;
            cmd_r      <= '0;
            cmd_valid  <= 1'b0;
            resp_shift <= '0;
            hold       <= '0;
            drdy_l     <= 1'b1;
        end else begin
            cmd_valid <= load_cmd;
            if (shift_cmd) cmd_shift <= cmd_next[CMD_W-2:0];
            if (load_cmd) begin
                cmd_r      <= cmd_next;
                resp_shift <= hold;
            end else if (shift_resp) begin
                resp_shift <= {resp_shift[RESP_W-2:0], 1'b0};
            end
            // a load in the consume cycle wins: old word goes out, new word stays pending
            if (bus.sample_valid) begin
                hold   <= bus.sample;
                drdy_l <= 1'b0;
            end else if (load_cmd) begin
                drdy_l <= 1'b1;
            end
        end
    end

    assign bus.miso        = miso;
    assign bus.miso_oe     = oe;
    assign bus.drdy_l      = drdy_l;
    assign bus.cmd         = cmd_r;
    assign bus.cmd_valid   = cmd_valid;
    assign bus.frame_done  = done;
    assign bus.frame_abort = abort;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a task-based mode-0 initiator plays vector-table frames.
module tb_spi_peripheral;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_peripheral_if #(.CMD_W(8), .RESP_W(24)) bus ();

    spi_peripheral #(.CMD_W(8), .RESP_W(24), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_abort = 0, n_cmdv = 0;

    always @(posedge clk) begin
        if (bus.frame_done)  n_done  <= n_done + 1;
        if (bus.frame_abort) n_abort <= n_abort + 1;
        if (bus.cmd_valid)   n_cmdv  <= n_cmdv + 1;
    end

    typedef struct {
        logic        load;
        logic [23:0] load_val;
        logic [7:0]  cmd;
        int          nclk;
        int          coll_rise;
        logic [23:0] coll_val;
        logic [7:0]  exp_cmd;
        logic [63:0] exp_rx;
        logic        exp_drdy;
        int          exp_done;
        int          exp_abort;
        int          exp_cmdv;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic half_period();
        repeat (8) @(negedge clk);
    endtask

    task automatic load_sample(input logic [23:0] v, input string tag);
        @(negedge clk);
        bus.sample       = v;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_drdy_after_load"}, 64'(bus.drdy_l), 64'h0);
    endtask

    task automatic do_frame(input logic [7:0] c, input int nclk, input int coll_rise,
                            input logic [23:0] coll_val, output logic [63:0] rx,
                            output logic oe_mid);
        rx = '0;
        oe_mid = 1'b0;
        bus.cs_l = 1'b0;
        for (int i = 0; i < nclk; i++) begin
            bus.mosi = (i < 8) ? c[7-i] : 1'b0;
            half_period();
            bus.sclk = 1'b1;
            rx = {rx[62:0], bus.miso};
            if (i == 2) oe_mid = bus.miso_oe;
            if (i + 1 == coll_rise) begin
                // land the load on the same clock as the 8th-rise consume
                repeat (2) @(negedge clk);
                bus.sample       = coll_val;
                bus.sample_valid = 1'b1;
                @(negedge clk);
                bus.sample_valid = 1'b0;
                repeat (5) @(negedge clk);
            end else begin
                half_period();
            end
            bus.sclk = 1'b0;
        end
        bus.mosi = 1'b0;
        half_period();
        bus.cs_l = 1'b1;
        half_period();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rx;
        logic        oe_mid;
        int          d0, a0, c0;

        vecs[0] = '{1'b1, 24'hAABBCC, 8'h87, 32, 0, 24'h0, 8'h87, 64'hAABBCC,   1'b1, 1, 0, 1};
        vecs[1] = '{1'b0, 24'h0,      8'h3C, 32, 0, 24'h0, 8'h3C, 64'hAABBCC,   1'b1, 1, 0, 1};
        vecs[2] = '{1'b1, 24'hAABBCC, 8'hF0, 5,  0, 24'h0, 8'h3C, 64'h0,        1'b0, 0, 1, 0};
        vecs[3] = '{1'b0, 24'h0,      8'h11, 32, 8, 24'h123456, 8'h11, 64'hAABBCC, 1'b0, 1, 0, 1};
        vecs[4] = '{1'b0, 24'h0,      8'h22, 32, 0, 24'h0, 8'h22, 64'h123456,   1'b1, 1, 0, 1};
        vecs[5] = '{1'b0, 24'h0,      8'h99, 40, 0, 24'h0, 8'h99, 64'h12345600, 1'b1, 1, 0, 1};

        bus.sclk = 1'b0;
        bus.cs_l = 1'b1;
        bus.mosi = 1'b0;
        bus.sample = '0;
        bus.sample_valid = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_miso",     64'(bus.miso),        64'h0);
        chk("rst_oe",       64'(bus.miso_oe),     64'h0);
        chk("rst_drdy",     64'(bus.drdy_l),      64'h1);
        chk("rst_cmd",      64'(bus.cmd),         64'h0);
        chk("rst_cmdv",     64'(bus.cmd_valid),   64'h0);
        chk("rst_done",     64'(bus.frame_done),  64'h0);
        chk("rst_abort",    64'(bus.frame_abort), 64'h0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].load) load_sample(vecs[i].load_val, $sformatf("v%0d", i));
            d0 = n_done; a0 = n_abort; c0 = n_cmdv;
            do_frame(vecs[i].cmd, vecs[i].nclk, vecs[i].coll_rise, vecs[i].coll_val, rx, oe_mid);
            chk($sformatf("v%0d_rx", i),     rx,                          vecs[i].exp_rx);
            chk($sformatf("v%0d_cmd", i),    64'(bus.cmd),                64'(vecs[i].exp_cmd));
            chk($sformatf("v%0d_drdy", i),   64'(bus.drdy_l),             64'(vecs[i].exp_drdy));
            chk($sformatf("v%0d_done", i),   64'(n_done - d0),            64'(vecs[i].exp_done));
            chk($sformatf("v%0d_abort", i),  64'(n_abort - a0),           64'(vecs[i].exp_abort));
            chk($sformatf("v%0d_cmdv", i),   64'(n_cmdv - c0),            64'(vecs[i].exp_cmdv));
            chk($sformatf("v%0d_oe_mid", i), 64'(oe_mid),                 64'h1);
            chk($sformatf("v%0d_oe_end", i), 64'(bus.miso_oe),            64'h0);
        end

        // asynchronous reset in the middle of the response phase
        bus.cs_l = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.mosi = i[0];
            half_period();
            bus.sclk = 1'b1;
            half_period();
            bus.sclk = 1'b0;
        end
        load_sample(24'h777777, "mid");
        chk("mid_oe_before_rst", 64'(bus.miso_oe), 64'h1);
        chk("mid_cmd_before_rst", 64'(bus.cmd), 64'h55);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso",  64'(bus.miso),        64'h0);
        chk("mid_rst_oe",    64'(bus.miso_oe),     64'h0);
        chk("mid_rst_drdy",  64'(bus.drdy_l),      64'h1);
        chk("mid_rst_cmd",   64'(bus.cmd),         64'h0);
        chk("mid_rst_cmdv",  64'(bus.cmd_valid),   64'h0);
        chk("mid_rst_done",  64'(bus.frame_done),  64'h0);
        chk("mid_rst_abort", 64'(bus.frame_abort), 64'h0);
        bus.cs_l = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        d0 = n_done;
        do_frame(8'h01, 32, 0, 24'h0, rx, oe_mid);
        chk("post_rst_rx",   rx,              64'h0);
        chk("post_rst_cmd",  64'(bus.cmd),    64'h01);
        chk("post_rst_drdy", 64'(bus.drdy_l), 64'h1);
        chk("post_rst_done", 64'(n_done - d0), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI responder (device side) that answers the team's `spi` initiator.
- Oversamples SCLK, CS_L and MOSI in the system clock domain, receives a CMD_W-bit command, then shifts a RESP_W-bit response word out on MISO, MSB first.
- Used as a synthesizable ADC/device model in benches and as a loopback target on the board.
- Mimics an ADC data-ready interface: DRDY_L_o, plus a holding register loaded by the sample source.

Parameters:
- CMD_W, 8, command length in bits.
- RESP_W, 24, response length in bits.
- SYNC_STAGES, 2, synchronizer flops on SCLK/CS_L/MOSI (≥2).

Ports:
- clock_i  input  1  system clock; must be ≥8× SCLK frequency.
- reset_L_i  input  1  asynchronous, active-low reset.
- SCLK_i  input  1  SPI clock from initiator (CPOL=0).
- CS_L_i  input  1  active-low chip select.
- MOSI_i  input  1  serial data in.
- MISO_o  output  1  serial data out.
- MISO_oe_o  output  1  MISO output enable; high only while CS_L_i is low after sync.
- sample_i  input  RESP_W  new response word.
- sample_valid_i  input  1  one-cycle pulse; loads sample_i into the holding register.
- DRDY_L_o  output  1  low while an unread sample is held.
- cmd_o  output  CMD_W  last received command.
- cmd_valid_o  output  1  one-cycle pulse when cmd_o updates.
- frame_done_o  output  1  one-cycle pulse when a frame completes with all CMD_W+RESP_W bits.
- frame_abort_o  output  1  one-cycle pulse when CS_L rises mid-frame.

Behaviour:
- Reset (async assert, sync deassert through the flops):
  - MISO_o=0, MISO_oe_o=0, DRDY_L_o=1, cmd_o=0.
  - All pulses 0, holding register 0, FSM=IDLE, synchronizers preset to SCLK=0, CS_L=1.
- Sampling and timing:
  - Inputs pass through SYNC_STAGES flops; edge detect runs on the synced signals.
  - Edge-to-action latency is SYNC_STAGES+1 clocks.
  - SPI mode 0: sample MOSI on SCLK rise; update MISO on SCLK fall.
- FSM states:
  - IDLE: wait for synced CS_L fall, then go to CMD; clear bit counter, MISO_oe_o=1, MISO_o=0.
  - CMD: shift MOSI into the command shift register on each rise.
    - On rise number CMD_W: cmd_o<=shift value; cmd_valid_o pulses next cycle.
    - Same cycle, response shift register <= holding register; DRDY_L_o<=1 (sample consumed); go to RESP.
  - RESP: on each fall, MISO_o <= response MSB, then shift left with 0 fill.
    - The first response bit is driven on the CMD_W-th fall, so the initiator samples bits on rises CMD_W+1 .. CMD_W+RESP_W.
    - Count RESP_W falls, then go to DONE.
  - DONE: further SCLK edges drive MISO_o=0. On CS_L rise: frame_done_o pulse, MISO_oe_o=0, go to IDLE.
- CS_L rise in CMD or RESP: frame_abort_o pulse, MISO_oe_o=0, go to IDLE.
  - If aborted in CMD, cmd_o is unchanged and the holding register is not consumed.
  - If aborted in RESP, the sample stays consumed.
- SCLK edges while CS_L is high are ignored.
- DRDY_L_o:
  - sample_valid_i sets the holding register and drives DRDY_L_o=0 the next cycle.
  - If sample_valid_i and the consume event occur in the same cycle, the consumed value is the old register. The new sample is loaded and DRDY_L_o stays 0 (load wins).
  - A new sample_valid_i while DRDY_L_o=0 overwrites the held value.
- Bit counter width is $clog2(CMD_W+RESP_W+1); it saturates in DONE and never wraps.

Decomposition:
- Package spi_pkg, shared with `spi`:
  - typedef spi_periph_state_t (IDLE, CMD, RESP, DONE).
  - Existing spi_mode_t.
  - Default constants SPI_CMD_W=8 and SPI_RESP_W=24.
- One sub-module: spi_sync_edge. It is a SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated for SCLK, CS_L and MOSI (MOSI uses only the level output).

Test Plan:
- Nominal frame: `spi` initiator in SPI_TX_RX with tx 0x87; sample_valid_i with 0xAABBCC beforehand.
  - cmd_o=0x87 with a single cmd_valid_o pulse.
  - Initiator rx_buffer=0xAABBCC.
  - frame_done_o pulses once; DRDY_L_o goes 0 then 1 after the 8th rise.
- No fresh sample: second frame with no new sample_valid_i → response equals the previous held value 0xAABBCC and DRDY_L_o stays 1.
- Command abort: CS_L rises after 5 SCLK cycles → frame_abort_o=1, cmd_o unchanged, DRDY_L_o still 0, MISO_oe_o=0.
- Load/consume collision: sample_valid_i(0x123456) in the same cycle as the 8th-rise consume.
  - Current frame returns the old word 0xAABBCC.
  - DRDY_L_o=0; the next frame returns 0x123456.
- Extra clocks: 40 SCLK cycles in one frame → bits 33-40 on MISO are 0; exactly one frame_done_o at CS_L rise.
- Reset mid-RESP: reset_L_i low after bit 10 → all outputs at reset values immediately. Next full frame is correct with cmd 0x01 and response 0x000000.
